// File: rtl/mmc1_ctrl_if.sv
// CPU/PPU bus bundle between the cartridge edge and the MMC1 bank controller.
interface mmc1_ctrl_if #(
    parameter int unsigned PRG_ADDR_W = 18,
    parameter int unsigned CHR_ADDR_W = 17
);
    logic                  m2;
    logic [14:0]           cpu_addr;
    logic [7:0]            cpu_data_i;
    logic                  cpu_rw;
    logic                  romsel;
    logic [13:0]           ppu_addr;
    logic [PRG_ADDR_W-1:0] prg_rom_addr;
    logic                  prg_ram_ce;
    logic [CHR_ADDR_W-1:0] chr_addr;
    logic                  ciram_ce;
    logic                  ciram_a10;
    logic [4:0]            ctrl_o;

    modport master (
        output m2, cpu_addr, cpu_data_i, cpu_rw, romsel, ppu_addr,
        input  prg_rom_addr, prg_ram_ce, chr_addr, ciram_ce, ciram_a10, ctrl_o
    );

    modport slave (
        input  m2, cpu_addr, cpu_data_i, cpu_rw, romsel, ppu_addr,
        output prg_rom_addr, prg_ram_ce, chr_addr, ciram_ce, ciram_a10, ctrl_o
    );
endinterface

// File: rtl/mmc1_ctrl.sv
// MMC1 (mapper 001) serial-load bank controller: PRG/CHR banking, mirroring, PRG-RAM enable.
// Optional macro MMC1_WRITE_FILTER_EN drops load writes on the edge right after a qualified write.
module mmc1_ctrl #(
    parameter int unsigned PRG_ADDR_W = 18,
    parameter int unsigned CHR_ADDR_W = 17
) (
    input  logic         clk_cpu,
    input  logic         rst,
    mmc1_ctrl_if.slave   bus
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 3;

    logic [REG_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REG_W-1:0] ctrl_q, ctrl_d;
    logic [REG_W-1:0] chr0_q, chr0_d;
    logic [REG_W-1:0] chr1_q, chr1_d;
    logic [REG_W-1:0] prg_q, prg_d;

    logic             wr_c;
    logic             blocked_c;
    logic [REG_W-1:0] shift_val_c;
    logic [3:0]       prg_bank_c;
    logic [4:0]       chr_bank_c;
    logic [17:0]      prg_full_c;
    logic [16:0]      chr_full_c;
    logic             unused_data_bits;

    assign wr_c        = bus.m2 & ~bus.cpu_rw & ~bus.romsel;
    assign shift_val_c = {bus.cpu_data_i[0], shift_q[4:1]};

`ifdef MMC1_WRITE_FILTER_EN
    logic wr_prev_q;

    // Remembers any qualified write so the second half of an RMW pair is dropped
    always_ff @(posedge clk_cpu or negedge rst) begin
        if (!rst) begin
            wr_prev_q <= 1'b0;
        end else begin
            wr_prev_q <= wr_c;
        end
    end

    assign blocked_c = wr_prev_q;
`else
    assign blocked_c = 1'b0;
`endif

    always_ff @(posedge clk_cpu or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            ctrl_q  <= 5'h0C;
            chr0_q  <= '0;
            chr1_q  <= '0;
            prg_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            chr0_q  <= chr0_d;
            chr1_q  <= chr1_d;
            prg_q   <= prg_d;
        end
    end

    // Serial loader: reset form always wins, load form commits on the fifth bit
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        chr0_d  = chr0_q;
        chr1_d  = chr1_q;
        prg_d   = prg_q;
        if (wr_c) begin
            if (bus.cpu_data_i[7]) begin
                shift_d     = '0;
                cnt_d       = '0;
                ctrl_d[3:2] = 2'b11;
            end else if (!blocked_c) begin
                if (cnt_q == 3'd4) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    case (bus.cpu_addr[14:13])
                        2'd0:    ctrl_d = shift_val_c;
                        2'd1:    chr0_d = shift_val_c;
                        2'd2:    chr1_d = shift_val_c;
                        default: prg_d  = shift_val_c;
                    endcase
                end else begin
                    shift_d = shift_val_c;
                    cnt_d   = cnt_q + 3'd1;
                end
            end
        end
    end

    always_comb begin
        prg_bank_c = 4'h0;
        case (ctrl_q[3:2])
            2'd0, 2'd1: prg_bank_c = {prg_q[3:1], bus.cpu_addr[14]};
            2'd2:       prg_bank_c = bus.cpu_addr[14] ? prg_q[3:0] : 4'h0;
            default:    prg_bank_c = bus.cpu_addr[14] ? 4'hF : prg_q[3:0];
        endcase
    end

    always_comb begin
        if (ctrl_q[4]) begin
            chr_bank_c = bus.ppu_addr[12] ? chr1_q : chr0_q;
        end else begin
            chr_bank_c = {chr0_q[4:1], bus.ppu_addr[12]};
        end
    end

    always_comb begin
        case (ctrl_q[1:0])
            2'd0:    bus.ciram_a10 = 1'b0;
            2'd1:    bus.ciram_a10 = 1'b1;
            2'd2:    bus.ciram_a10 = bus.ppu_addr[10];
            default: bus.ciram_a10 = bus.ppu_addr[11];
        endcase
    end

    // Full-width addresses are cut or zero-extended to the cart's actual size
    assign prg_full_c       = {prg_bank_c, bus.cpu_addr[13:0]};
    assign chr_full_c       = {chr_bank_c, bus.ppu_addr[11:0]};
    assign bus.prg_rom_addr = PRG_ADDR_W'(prg_full_c);
    assign bus.chr_addr     = CHR_ADDR_W'(chr_full_c);
    assign bus.ciram_ce     = ~bus.ppu_addr[13];
    assign bus.prg_ram_ce   = bus.romsel & bus.m2 & (bus.cpu_addr[14:13] == 2'b11) & ~prg_q[4];
    assign bus.ctrl_o       = ctrl_q;

    assign unused_data_bits = ^bus.cpu_data_i[6:1];

endmodule

// File: tb/tb_mmc1_ctrl.sv
// Directed bench for mmc1_ctrl: serial loads, reset form, RMW filter, banking and mirroring.
module tb_mmc1_ctrl;

    logic clk;
    logic rst_n;

    mmc1_ctrl_if #(.PRG_ADDR_W(18), .CHR_ADDR_W(17)) bus ();

    mmc1_ctrl #(.PRG_ADDR_W(18), .CHR_ADDR_W(17)) dut (
        .clk_cpu (clk),
        .rst     (rst_n),
        .bus     (bus)
    );

    localparam int SEL_CTRL = 0;
    localparam int SEL_PRG  = 1;
    localparam int SEL_CHR  = 2;
    localparam int SEL_A10  = 3;
    localparam int SEL_CE   = 4;
    localparam int SEL_RAM  = 5;

    int          vectors;
    int          miscompares;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            SEL_CTRL: return 32'(bus.ctrl_o);
            SEL_PRG:  return 32'(bus.prg_rom_addr);
            SEL_CHR:  return 32'(bus.chr_addr);
            SEL_A10:  return 32'(bus.ciram_a10);
            SEL_CE:   return 32'(bus.ciram_ce);
            default:  return 32'(bus.prg_ram_ce);
        endcase
    endfunction

    task automatic idle();
        bus.m2     = 1'b1;
        bus.cpu_rw = 1'b1;
        bus.romsel = 1'b1;
    endtask

    task automatic wr(input logic [14:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.m2 = 1'b1; bus.cpu_rw = 1'b0; bus.romsel = 1'b0;
        bus.cpu_addr = a; bus.cpu_data_i = d;
        @(negedge clk);
        idle();
    endtask

    // Five spaced single-bit writes, LSB first
    task automatic wr5(input logic [14:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) wr(a, {7'b0, v[i]});
    endtask

    task automatic wr2(input logic [14:0] a, input logic [7:0] d1, input logic [7:0] d2);
        @(negedge clk);
        bus.m2 = 1'b1; bus.cpu_rw = 1'b0; bus.romsel = 1'b0;
        bus.cpu_addr = a; bus.cpu_data_i = d1;
        @(negedge clk);
        bus.cpu_data_i = d2;
        @(negedge clk);
        idle();
    endtask

    // Drive a read/PPU probe, queue its expectation, then compare once outputs settle
    task automatic step(input logic [14:0] ca, input logic rs, input logic [13:0] pa,
                        input int sel, input logic [31:0] exp, input string tag);
        logic [31:0] got;
        logic [31:0] e;
        string       t;
        @(negedge clk);
        bus.m2 = 1'b1; bus.cpu_rw = 1'b1; bus.romsel = rs;
        bus.cpu_addr = ca; bus.ppu_addr = pa;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        #1;
        got = sample(sel);
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        vectors++;
        assert (got === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", t, got, e);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        bus.m2 = 1'b0; bus.cpu_rw = 1'b1; bus.romsel = 1'b1;
        bus.cpu_addr = '0; bus.cpu_data_i = '0; bus.ppu_addr = '0;

        // Reset state
        step(15'h0000, 1'b0, 14'h0000, SEL_CTRL, 32'h0C, "in_reset_ctrl");
        @(negedge clk);
        rst_n = 1'b1;
        step(15'h0000, 1'b0, 14'h0000, SEL_CTRL, 32'h0C,    "rst_ctrl");
        step(15'h4000, 1'b0, 14'h0000, SEL_PRG,  32'h3C000, "rst_prg_c000");
        step(15'h0000, 1'b0, 14'h0000, SEL_PRG,  32'h00000, "rst_prg_8000");
        step(15'h0000, 1'b1, 14'h2400, SEL_A10,  32'h0,     "rst_a10");
        step(15'h0000, 1'b1, 14'h2000, SEL_CE,   32'h0,     "ciram_ce_nt");
        step(15'h0000, 1'b1, 14'h0000, SEL_CE,   32'h1,     "ciram_ce_pat");
        step(15'h6000, 1'b1, 14'h0000, SEL_RAM,  32'h1,     "rst_ram_ce");
        step(15'h0000, 1'b1, 14'h1ABC, SEL_CHR,  32'h01ABC, "rst_chr_8k");

        // ctrl = 0x02: vertical mirroring, 32 KB PRG
        for (int i = 0; i < 4; i++) wr(15'h0000, {7'b0, i == 1});
        step(15'h0000, 1'b1, 14'h0000, SEL_CTRL, 32'h0C, "ctrl_before_5th");
        wr(15'h0000, 8'h00);
        step(15'h0000, 1'b1, 14'h0000, SEL_CTRL, 32'h02,    "ctrl_02");
        step(15'h0000, 1'b1, 14'h2400, SEL_A10,  32'h1,     "vert_2400");
        step(15'h0000, 1'b1, 14'h2800, SEL_A10,  32'h0,     "vert_2800");
        step(15'h4000, 1'b0, 14'h0000, SEL_PRG,  32'h04000, "prg32k_c000");

        // Mode 3 via reset form, prg = 5
        wr(15'h0000, 8'h80);
        step(15'h0000, 1'b1, 14'h0000, SEL_CTRL, 32'h0E, "reset_form_ctrl");
        wr5(15'h6000, 5'h05);
        step(15'h0000, 1'b0, 14'h0000, SEL_PRG, 32'h14000, "mode3_8000");
        step(15'h4000, 1'b0, 14'h0000, SEL_PRG, 32'h3C000, "mode3_c000");
        wr5(15'h0000, 5'h0A);
        step(15'h0000, 1'b0, 14'h0000, SEL_PRG, 32'h00000, "mode2_8000");
        step(15'h4000, 1'b0, 14'h0000, SEL_PRG, 32'h14000, "mode2_c000");

        // Partial load aborted by reset form (issued back-to-back), then chr0 = 3
        wr(15'h0000, 8'h01);
        wr(15'h0000, 8'h01);
        wr2(15'h0000, 8'h01, 8'h80);
        step(15'h0000, 1'b1, 14'h0000, SEL_CTRL, 32'h0E, "abort_ctrl");
        wr5(15'h2000, 5'h03);
        step(15'h0000, 1'b1, 14'h0ABC, SEL_CHR, 32'h02ABC, "chr0_3_lo");
        step(15'h0000, 1'b1, 14'h1ABC, SEL_CHR, 32'h03ABC, "chr0_3_hi");

        // RMW pair followed by four spaced writes of 1
        wr2(15'h0000, 8'h01, 8'h00);
        for (int i = 0; i < 4; i++) wr(15'h0000, 8'h01);
        wr(15'h0000, 8'h80);
`ifdef MMC1_WRITE_FILTER_EN
        step(15'h0000, 1'b1, 14'h0000, SEL_CTRL, 32'h1F, "rmw_filtered");
`else
        step(15'h0000, 1'b1, 14'h0000, SEL_CTRL, 32'h1D, "rmw_unfiltered");
`endif

        // 4 KB CHR mode and PRG-RAM disable
        wr5(15'h0000, 5'h10);
        wr5(15'h2000, 5'h02);
        wr5(15'h4000, 5'h07);
        wr5(15'h6000, 5'h10);
        step(15'h0000, 1'b1, 14'h0000, SEL_CTRL, 32'h10,    "ctrl_10");
        step(15'h0000, 1'b1, 14'h1ABC, SEL_CHR,  32'h07ABC, "chr4k_hi");
        step(15'h0000, 1'b1, 14'h0ABC, SEL_CHR,  32'h02ABC, "chr4k_lo");
        step(15'h0000, 1'b1, 14'h2C00, SEL_A10,  32'h0,     "mirror_one_lo");
        step(15'h6000, 1'b1, 14'h0000, SEL_RAM,  32'h0,     "ram_ce_off");
        step(15'h4000, 1'b0, 14'h0000, SEL_PRG,  32'h04000, "prg32k_bank10");
        wr5(15'h0000, 5'h13);
        step(15'h0000, 1'b1, 14'h2800, SEL_A10, 32'h1, "horiz_2800");
        step(15'h0000, 1'b1, 14'h2400, SEL_A10, 32'h0, "horiz_2400");

        // Async reset mid-sequence, then ignored non-write cycles
        wr(15'h0000, 8'h01);
        wr(15'h0000, 8'h01);
        @(negedge clk);
        rst_n = 1'b0;
        step(15'h0000, 1'b1, 14'h0000, SEL_CTRL, 32'h0C, "async_rst_ctrl");
        step(15'h6000, 1'b1, 14'h0000, SEL_RAM,  32'h1,  "async_rst_ram_ce");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.m2 = 1'b1; bus.cpu_rw = 1'b0; bus.romsel = 1'b1; bus.cpu_data_i = 8'h01;
        @(negedge clk);
        bus.m2 = 1'b1; bus.cpu_rw = 1'b1; bus.romsel = 1'b0;
        @(negedge clk);
        bus.m2 = 1'b0; bus.cpu_rw = 1'b0; bus.romsel = 1'b0;
        @(negedge clk);
        idle();
        wr5(15'h0000, 5'h02);
        step(15'h0000, 1'b1, 14'h0000, SEL_CTRL, 32'h02, "post_rst_load");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmc1_ctrl.md
Name: mmc1_ctrl

Overview:
Bank-switching controller for MMC1 (mapper 001) carts. It sits between the CPU/PPU buses and the cart PRG/CHR memories, in place of the fixed mapping that mapper-000 carts use. It decodes serial CPU writes to $8000-$FFFF into four internal configuration registers. From those registers it generates banked PRG/CHR addresses, CIRAM mirroring and the PRG-RAM chip enable.

Parameters:
PRG_ADDR_W, 18, PRG ROM byte-address width (18 = 256 KB, 16 banks of 16 KB)
CHR_ADDR_W, 17, CHR byte-address width (17 = 128 KB, 32 banks of 4 KB)

Ports:
clk_cpu  input  1  CPU-cycle clock; one rising edge per CPU bus cycle
rst  input  1  asynchronous, active-low reset
m2  input  1  CPU phase-2; bus data valid while high
cpu_addr  input  15  CPU A14..A0
cpu_data_i  input  8  CPU write data
cpu_rw  input  1  1 = read, 0 = write
romsel  input  1  active-low; 0 = access to $8000-$FFFF
ppu_addr  input  14  PPU address
prg_rom_addr  output  PRG_ADDR_W  banked PRG ROM address
prg_ram_ce  output  1  active-high PRG-RAM ($6000-$7FFF) enable
chr_addr  output  CHR_ADDR_W  banked CHR address
ciram_ce  output  1  active-low; equals ppu_addr[13] inverted-sense (0 when ppu_addr[13]=1)
ciram_a10  output  1  nametable select
ctrl_o  output  5  control register, for debug/verification

Behaviour:
- Write qualifier: wr = m2 & ~cpu_rw & ~romsel. It is sampled on the clk_cpu rising edge.
- Filter: a qualified write is ignored if a write was accepted on the immediately preceding clk_cpu edge. The filter flag records any qualified write, including the reset form and ignored writes. This prevents RMW double-writes.
- Reset form, cpu_data_i[7]=1: clears the shift register and the count to 0, and sets ctrl[3:2]=2'b11. Other registers are unchanged. Honoured even when the filter would ignore the write.
- Load form, cpu_data_i[7]=0: shift = {cpu_data_i[0], shift[4:1]} and cnt++.
  - On the 5th write (cnt=4), value = {cpu_data_i[0], shift[4:1]} commits to the register selected by cpu_addr[14:13] of that 5th write: 0 ctrl, 1 chr0, 2 chr1, 3 prg.
  - The commit is visible on the next edge. The same edge clears shift and cnt.
- rst low, at any time including mid-sequence: ctrl=5'h0C, chr0=chr1=prg=0, shift=0, cnt=0, filter flag=0.
- Post-reset outputs: ciram_a10=0 and the PRG mode is "fix last".
- Mirroring, from ctrl[1:0]:
  - 0: ciram_a10=0
  - 1: ciram_a10=1
  - 2: ciram_a10=ppu_addr[10] (vertical)
  - 3: ciram_a10=ppu_addr[11] (horizontal)
- PRG bank (4 bits), selected by ctrl[3:2], with cpu_addr[14]=1 meaning $C000:
  - 0 or 1 (32 KB mode): {prg[3:1], cpu_addr[14]}
  - 2: cpu_addr[14] ? prg[3:0] : 0
  - 3: cpu_addr[14] ? 4'hF : prg[3:0]
  - prg_rom_addr = {bank, cpu_addr[13:0]}. The bank is truncated or zero-extended to PRG_ADDR_W-14 bits; upper bits wrap.
- CHR bank (5 bits):
  - ctrl[4]=0 (8 KB mode): {chr0[4:1], ppu_addr[12]}
  - ctrl[4]=1: ppu_addr[12] ? chr1 : chr0
  - chr_addr = {bank, ppu_addr[11:0]}, fitted to CHR_ADDR_W.
- prg_ram_ce = romsel & m2 & (cpu_addr[14:13]==2'b11) & ~prg[4].
- All address, mirroring and enable outputs are combinational from the registers plus the live buses. There is no added latency beyond the register commit.
- Reads and accesses with romsel=1 never affect state.

Optional Feature:
MMC1_WRITE_FILTER_EN
- Defined: the consecutive-cycle write filter is active, as above.
- Undefined: every qualified write is processed. The filter flag logic is removed.

Test Plan:
- Reset release → ctrl_o=5'h0C. With cpu_addr=15'h4000 and romsel=0: prg_rom_addr=18'h3C000. With cpu_addr=0: prg_rom_addr=0. ciram_a10=0.
- Five spaced writes to $8000 with bits 0,1,0,0,0 → ctrl=5'h02. ppu_addr=14'h2400 → ciram_a10=1; ppu_addr=14'h2800 → ciram_a10=0.
- Five spaced writes to $E000 with bits 1,0,1,0,0 (prg=5) in mode 3 → cpu_addr 15'h0000 gives prg_rom_addr=18'h14000.
- Three load writes, then a write of 8'h80 → cnt cleared and ctrl[3:2]=2'b11. Five further writes to $A000 with bits 1,1,0,0,0 → chr0=3.
- Two writes on back-to-back edges (RMW): only the first shifts when MMC1_WRITE_FILTER_EN is defined; both shift when it is undefined.
- Set ctrl=5'h10, chr0=2, chr1=7 → ppu_addr=14'h1ABC gives chr_addr=17'h07ABC. prg=5'h10 → prg_ram_ce stays 0 for accesses to $6000.
